// File: rtl/scaler_hline_ctrl.sv
// Horizontal nearest-neighbour scaling controller around an external 8b x 4096
// simple-dual-port RAM split into two 2048-pixel ping-pong line banks.
// The write side stores incoming lines, and the read side resamples each
// completed line at a fixed-point step. Results go out on a valid/ready stream
// through a 2-entry skid FIFO.
module scaler_hline_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 12,
  parameter int FRAC       = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  input  logic [DATA_WIDTH-1:0]          in_data,
  input  logic                           in_eol,
  input  logic [ADDR_WIDTH-1+FRAC-1:0]   cfg_step,
  input  logic [ADDR_WIDTH-1:0]          cfg_out_width,
  output logic                           ram_wr_en,
  output logic [ADDR_WIDTH-1:0]          ram_wr_addr,
  output logic [DATA_WIDTH-1:0]          ram_wr_data,
  output logic [ADDR_WIDTH-1:0]          ram_rd_addr,
  input  logic [DATA_WIDTH-1:0]          ram_rd_data,
  output logic                           out_valid,
  output logic [DATA_WIDTH-1:0]          out_data,
  output logic                           out_eol,
  input  logic                           out_ready,
  output logic                           overflow
);

  // Pixel index width inside one bank, step width, and accumulator width.
  // The accumulator has room for out_width * max_step, so it never wraps.
  localparam int PIX_W  = ADDR_WIDTH - 1;
  localparam int STEP_W = PIX_W + FRAC;
  localparam int ACC_W  = ADDR_WIDTH + STEP_W;
  localparam int IDX_W  = ACC_W - FRAC;

  localparam logic [PIX_W-1:0]      CNT_MAX  = {PIX_W{1'b1}};
  localparam logic [ADDR_WIDTH-1:0] LINE_MAX = {1'b1, {PIX_W{1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // Shared bank bookkeeping
  // ---------------------------------------------------------------------------
  logic [1:0]            bank_full_q, bank_full_d;
  logic [ADDR_WIDTH-1:0] len_q [2];

  // ---------------------------------------------------------------------------
  // Write side state
  // ---------------------------------------------------------------------------
  logic                  wr_bank_q;
  logic [PIX_W-1:0]      wr_cnt_q;
  logic                  line_sat_q;     // pixel 2047 of this line already stored
  logic                  overflow_q;
  logic                  ram_wr_en_q;
  logic [ADDR_WIDTH-1:0] ram_wr_addr_q;
  logic [DATA_WIDTH-1:0] ram_wr_data_q;

  logic                  rel_same_bank;
  logic                  wr_blocked;
  logic                  wr_accept;
  logic                  wr_drop;
  logic                  wr_line_done;
  logic [ADDR_WIDTH-1:0] wr_len;

  // ---------------------------------------------------------------------------
  // Read side state
  // ---------------------------------------------------------------------------
  state_e                state_q, state_d;
  logic                  rd_bank_q;
  logic [ACC_W-1:0]      acc_q;
  logic [ADDR_WIDTH-1:0] oc_q;
  logic [STEP_W-1:0]     step_q;
  logic [ADDR_WIDTH-1:0] width_q;
  logic [ADDR_WIDTH-1:0] rlen_q;
  logic                  inflight_q;
  logic                  inflight_eol_q;

  logic                  rd_start;
  logic                  rd_release;
  logic                  rd_issue;
  logic                  rd_last;
  logic [IDX_W-1:0]      src_idx;
  logic [ADDR_WIDTH-1:0] last_idx;
  logic [PIX_W-1:0]      rd_pix;

  // ---------------------------------------------------------------------------
  // Output FIFO state
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] fifo_data_q [2];
  logic                  fifo_eol_q  [2];
  logic                  fifo_wp_q;
  logic                  fifo_rp_q;
  logic [1:0]            fifo_cnt_q;
  logic                  fifo_pop;
  logic [2:0]            fifo_occ;
  logic                  fifo_room;

  // Decide per input pixel whether it is stored or dropped, and what length a
  // finishing line records.
  always_comb begin
    // NOTE: every signal driven here gets a value on every path before any
    // condition is evaluated; a missed path would otherwise infer a latch.
    rel_same_bank = rd_release && (rd_bank_q == wr_bank_q);
    // A full bank that the reader frees in this very cycle counts as free.
    wr_blocked    = bank_full_q[wr_bank_q] && !rel_same_bank;
    wr_accept     = in_valid && !wr_blocked && !line_sat_q;
    wr_drop       = in_valid && (wr_blocked || line_sat_q);
    wr_line_done  = in_valid && in_eol && !wr_blocked;
    wr_len        = line_sat_q ? LINE_MAX : ({1'b0, wr_cnt_q} + ADDR_WIDTH'(1));
  end

  // Merge write completion and read release; both may hit in one cycle.
  always_comb begin
    bank_full_d = bank_full_q;
    if (rd_release) begin
      bank_full_d[rd_bank_q] = 1'b0;
    end
    if (wr_line_done) begin
      bank_full_d[wr_bank_q] = 1'b1;
    end
  end

  // Write-side registers: RAM write port copy, pixel counter, bank toggling.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (rst) begin
      wr_bank_q     <= 1'b0;
      wr_cnt_q      <= '0;
      line_sat_q    <= 1'b0;
      overflow_q    <= 1'b0;
      ram_wr_en_q   <= 1'b0;
      ram_wr_addr_q <= '0;
      ram_wr_data_q <= '0;
      bank_full_q   <= '0;
      len_q[0]      <= '0;
      len_q[1]      <= '0;
    end else begin
      bank_full_q <= bank_full_d;
      ram_wr_en_q <= wr_accept;
      if (wr_accept) begin
        ram_wr_addr_q <= {wr_bank_q, wr_cnt_q};
        ram_wr_data_q <= in_data;
      end
      if (wr_drop) begin
        overflow_q <= 1'b1;
      end
      if (in_valid && in_eol) begin
        wr_cnt_q   <= '0;
        line_sat_q <= 1'b0;
        if (wr_line_done) begin
          len_q[wr_bank_q] <= wr_len;
          wr_bank_q        <= ~wr_bank_q;
        end
      end else if (wr_accept) begin
        if (wr_cnt_q == CNT_MAX) begin
          line_sat_q <= 1'b1;
        end else begin
          wr_cnt_q <= wr_cnt_q + PIX_W'(1);
        end
      end
    end
  end

  // FIFO pop and issue throttle. A read issued now is captured next cycle. So
  // it is allowed only if the FIFO, after this cycle's pop and the pending
  // capture, still has a free slot. This keeps 1 pixel/clk when out_ready is high.
  always_comb begin
    fifo_pop  = (fifo_cnt_q != 2'd0) && out_ready;
    fifo_occ  = {1'b0, fifo_cnt_q} + {2'b00, inflight_q} - {2'b00, fifo_pop};
    fifo_room = (fifo_occ < 3'd2);
  end

  // Read source address: integer part of the accumulator, clamped to the last
  // stored pixel so steps past the end repeat it.
  always_comb begin
    src_idx  = acc_q[ACC_W-1:FRAC];
    last_idx = rlen_q - ADDR_WIDTH'(1);
    if (src_idx > IDX_W'(last_idx)) begin
      rd_pix = last_idx[PIX_W-1:0];
    end else begin
      rd_pix = src_idx[PIX_W-1:0];
    end
    rd_last = (oc_q == (width_q - ADDR_WIDTH'(1)));
  end

  assign ram_rd_addr = {rd_bank_q, rd_pix};

  // Read FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Read FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bank_full_q[rd_bank_q] && (cfg_out_width != '0)) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (fifo_room && rd_last) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!inflight_q) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Read FSM outputs: line start, read issue, and bank release.
  always_comb begin
    rd_start   = 1'b0;
    rd_release = 1'b0;
    rd_issue   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bank_full_q[rd_bank_q]) begin
          // A zero output width discards the line without reading it.
          if (cfg_out_width == '0) begin
            rd_release = 1'b1;
          end else begin
            rd_start = 1'b1;
          end
        end
      end
      ST_RUN:   rd_issue   = fifo_room;
      ST_DRAIN: rd_release = !inflight_q;
      default:  ;
    endcase
  end

  // Read datapath: sample the config at line start, then step the accumulator
  // once per issued read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_bank_q      <= 1'b0;
      acc_q          <= '0;
      oc_q           <= '0;
      step_q         <= '0;
      width_q        <= '0;
      rlen_q         <= '0;
      inflight_q     <= 1'b0;
      inflight_eol_q <= 1'b0;
    end else begin
      if (rd_start) begin
        acc_q   <= '0;
        oc_q    <= '0;
        step_q  <= cfg_step;
        width_q <= cfg_out_width;
        rlen_q  <= len_q[rd_bank_q];
      end else if (rd_issue) begin
        acc_q <= acc_q + ACC_W'(step_q);
        oc_q  <= oc_q + ADDR_WIDTH'(1);
      end
      if (rd_release) begin
        rd_bank_q <= ~rd_bank_q;
      end
      inflight_q     <= rd_issue;
      inflight_eol_q <= rd_issue && rd_last;
    end
  end

  // Output FIFO: capture the RAM data one cycle after issue and pop on handshake.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the two FIFO slots are reset because out_data reads them directly
    // and must be 0 out of reset; the large line store lives in the external
    // RAM and is never cleared, since a line is only read after it is written.
    if (rst) begin
      fifo_data_q[0] <= '0;
      fifo_data_q[1] <= '0;
      fifo_eol_q[0]  <= 1'b0;
      fifo_eol_q[1]  <= 1'b0;
      fifo_wp_q      <= 1'b0;
      fifo_rp_q      <= 1'b0;
      fifo_cnt_q     <= 2'd0;
    end else begin
      if (inflight_q) begin
        fifo_data_q[fifo_wp_q] <= ram_rd_data;
        fifo_eol_q[fifo_wp_q]  <= inflight_eol_q;
        fifo_wp_q              <= ~fifo_wp_q;
      end
      if (fifo_pop) begin
        fifo_rp_q <= ~fifo_rp_q;
      end
      fifo_cnt_q <= fifo_cnt_q + {1'b0, inflight_q} - {1'b0, fifo_pop};
    end
  end

  assign out_valid   = (fifo_cnt_q != 2'd0);
  assign out_data    = fifo_data_q[fifo_rp_q];
  assign out_eol     = out_valid && fifo_eol_q[fifo_rp_q];
  assign overflow    = overflow_q;
  assign ram_wr_en   = ram_wr_en_q;
  assign ram_wr_addr = ram_wr_addr_q;
  assign ram_wr_data = ram_wr_data_q;

endmodule

// File: tb/tb_scaler_hline_ctrl.sv
// Bench for scaler_hline_ctrl. It contains a behavioural RAM and a line-level
// reference model. Each output pixel is computed as
// line[min(floor(i*step/2^16), len-1)].
module tb_scaler_hline_ctrl;

  localparam int DW   = 8;
  localparam int AW   = 12;
  localparam int FRAC = 16;
  localparam int SW   = AW - 1 + FRAC;

  typedef logic [7:0] pix_q_t [$];

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_eol;
  logic [SW-1:0] cfg_step;
  logic [AW-1:0] cfg_out_width;
  logic          ram_wr_en;
  logic [AW-1:0] ram_wr_addr;
  logic [DW-1:0] ram_wr_data;
  logic [AW-1:0] ram_rd_addr;
  logic [DW-1:0] ram_rd_data;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_eol;
  logic          out_ready;
  logic          overflow;

  scaler_hline_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FRAC(FRAC)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_eol        (in_eol),
    .cfg_step      (cfg_step),
    .cfg_out_width (cfg_out_width),
    .ram_wr_en     (ram_wr_en),
    .ram_wr_addr   (ram_wr_addr),
    .ram_wr_data   (ram_wr_data),
    .ram_rd_addr   (ram_rd_addr),
    .ram_rd_data   (ram_rd_data),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .out_eol       (out_eol),
    .out_ready     (out_ready),
    .overflow      (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM with a registered read port and no output register.
  logic [DW-1:0] mem [4096];
  always @(posedge clk) begin
    if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
    ram_rd_data <= mem[ram_rd_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          tests = 0;
  int          fails = 0;
  logic [8:0]  exp_q [$];
  int          pop_cyc [$];
  int          eol_seen = 0;
  int          rdy_mode = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: source index of output pixel i.
  function automatic int model_idx(input int i, input int unsigned step, input int len);
    longint unsigned pos;
    pos = (longint'(i) * longint'(step)) >> FRAC;
    if (pos > longint'(len - 1)) return len - 1;
    return int'(pos);
  endfunction

  task automatic push_line(input pix_q_t px, input int unsigned step, input int w);
    int len;
    len = (px.size() > 2048) ? 2048 : px.size();
    for (int i = 0; i < w; i++) exp_q.push_back({(i == w - 1), px[model_idx(i, step, len)]});
  endtask

  // Downstream ready pattern.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = !out_ready;
        2:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Compare process. It checks every handshake against the model queue and
  // checks that the output holds steady while stalled.
  logic       stall_q = 1'b0;
  logic [8:0] held_q  = '0;
  logic [8:0] exp_e;
  always @(negedge clk) begin
    if (rst) begin
      stall_q = 1'b0;
      check("rst_out_valid", out_valid, 0);
    end else begin
      if (stall_q) begin
        check("stall_valid", out_valid, 1);
        check("stall_hold", {out_eol, out_data}, held_q);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL out_extra: got 0x%0h, queue empty (cycle %0d)", {out_eol, out_data}, cyc);
        end else begin
          exp_e = exp_q.pop_front();
          check("out_pix", {out_eol, out_data}, exp_e);
        end
        if (out_eol) eol_seen++;
        pop_cyc.push_back(cyc);
      end
      stall_q = out_valid && !out_ready;
      held_q  = {out_eol, out_data};
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_line(input pix_q_t px, input bit gaps);
    for (int i = 0; i < px.size(); i++) begin
      if (gaps) begin
        while ($urandom_range(0, 3) == 0) begin
          in_valid = 1'b0; in_eol = 1'b0;
          @(posedge clk); #1;
        end
      end
      in_valid = 1'b1;
      in_data  = px[i];
      in_eol   = (i == px.size() - 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_eol   = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin @(posedge clk); #1; k++; end
    check("drain_timeout", exp_q.size(), 0);
    idle(4);
  endtask

  task automatic wait_eols(input int target, input int budget);
    int k;
    k = 0;
    while (eol_seen < target && k < budget) begin @(posedge clk); #1; k++; end
    check("eol_timeout", (eol_seen >= target), 1);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    exp_q.delete();
    idle(2);
    rst = 1'b0;
    idle(2);
  endtask

  function automatic pix_q_t ramp(input int n);
    pix_q_t q;
    for (int i = 0; i < n; i++) q.push_back(8'(i));
    return q;
  endfunction

  function automatic pix_q_t rand_line(input int n);
    pix_q_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  // Watchdog: the bench must never hang.
  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, %0d tests run", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    pix_q_t px, pa, pb, pc;
    int lit2 [6] = '{0, 2, 4, 6, 7, 7};
    int span;
    int unsigned step;
    int w, base, len;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_eol = 1'b0;
    cfg_step = SW'(32'h10000); cfg_out_width = AW'(8);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_eol", out_eol, 0);
    check("rst_ovf", overflow, 0);
    check("rst_wr_en", ram_wr_en, 0);
    check("rst_wr_addr", ram_wr_addr, 0);
    check("rst_wr_data", ram_wr_data, 0);
    check("rst_rd_addr", ram_rd_addr, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);

    // Pin the model against hand-derived index sequences.
    for (int i = 0; i < 8; i++)  check("pin_unity", model_idx(i, 32'h10000, 8), i);
    for (int i = 0; i < 16; i++) check("pin_half", model_idx(i, 32'h8000, 8), i / 2);
    for (int i = 0; i < 6; i++)  check("pin_double", model_idx(i, 32'h20000, 8), lit2[i]);

    // Unity step, full throughput.
    rdy_mode = 0;
    px = ramp(8);
    cfg_step = SW'(32'h10000); cfg_out_width = AW'(8);
    pop_cyc.delete();
    push_line(px, 32'h10000, 8);
    send_line(px, 1'b0);
    wait_drain(2000);
    check("tput_count", pop_cyc.size(), 8);
    span = (pop_cyc.size() > 0) ? (pop_cyc[pop_cyc.size() - 1] - pop_cyc[0]) : -1;
    check("tput_span", span, 7);

    // Half step: every pixel repeated.
    cfg_step = SW'(32'h8000); cfg_out_width = AW'(16);
    push_line(px, 32'h8000, 16);
    send_line(px, 1'b0);
    wait_drain(2000);

    // Double step, running past the end: clamped to the last pixel.
    cfg_step = SW'(32'h20000); cfg_out_width = AW'(6);
    push_line(px, 32'h20000, 6);
    send_line(px, 1'b0);
    wait_drain(2000);

    // Toggling ready: no loss, no duplicate, stable while stalled.
    rdy_mode = 1;
    cfg_step = SW'(32'h10000); cfg_out_width = AW'(8);
    push_line(px, 32'h10000, 8);
    send_line(px, 1'b0);
    wait_drain(2000);
    px = rand_line(30);
    cfg_step = SW'(32'h14000); cfg_out_width = AW'(25);
    push_line(px, 32'h14000, 25);
    send_line(px, 1'b1);
    wait_drain(2000);

    // Three back-to-back lines with the sink blocked: the third is dropped.
    rdy_mode = 0;
    check("ovf_clear", overflow, 0);
    rdy_mode = 3;
    idle(2);
    cfg_step = SW'(32'h10000); cfg_out_width = AW'(8);
    pa = rand_line(8); pb = rand_line(8); pc = rand_line(8);
    push_line(pa, 32'h10000, 8);
    push_line(pb, 32'h10000, 8);
    send_line(pa, 1'b0);
    send_line(pb, 1'b0);
    send_line(pc, 1'b0);
    idle(20);
    check("ovf_set", overflow, 1);
    check("blocked_no_pop", exp_q.size(), 16);
    rdy_mode = 0;
    wait_drain(2000);
    idle(40);

    // Reset in the middle of a read.
    reset_dut();
    check("ovf_after_rst", overflow, 0);
    rdy_mode = 2;
    px = rand_line(20);
    cfg_step = SW'(32'h10000); cfg_out_width = AW'(40);
    push_line(px, 32'h10000, 40);
    send_line(px, 1'b0);
    begin
      int k;
      k = 0;
      while (exp_q.size() > 30 && k < 1000) begin @(posedge clk); #1; k++; end
      check("pre_rst_progress", (exp_q.size() <= 30), 1);
    end
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("midrst_valid", out_valid, 0);
    check("midrst_eol", out_eol, 0);
    check("midrst_data", out_data, 0);
    check("midrst_wr_en", ram_wr_en, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);
    rdy_mode = 0;
    px = rand_line(12);
    cfg_step = SW'(32'h18000); cfg_out_width = AW'(10);
    push_line(px, 32'h18000, 10);
    send_line(px, 1'b0);
    wait_drain(2000);
    check("post_rst_ovf", overflow, 0);

    // Over-long line: only the first 2048 pixels are kept.
    px = rand_line(2050);
    step = 200 << 16;
    cfg_step = SW'(step); cfg_out_width = AW'(12);
    push_line(px, step, 12);
    send_line(px, 1'b0);
    wait_drain(4000);
    check("long_ovf", overflow, 1);
    reset_dut();

    // Randomised batches. Config is fixed per batch, and line k is sent only
    // once line k-2 has left, so no line is dropped.
    for (int b = 0; b < 8; b++) begin
      step = $urandom_range(32'h2000, 32'h40000);
      w    = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 60);
      rdy_mode = b % 3;
      base = eol_seen;
      cfg_step = SW'(step); cfg_out_width = AW'(w);
      for (int k = 0; k < 6; k++) begin
        if (k >= 2) begin
          if (w != 0) wait_eols(base + k - 1, 20000);
          idle(4);
        end
        len = ($urandom_range(0, 3) == 0) ? $urandom_range(41, 200) : $urandom_range(1, 40);
        px = rand_line(len);
        push_line(px, step, w);
        send_line(px, 1'b1);
      end
      wait_drain(40000);
      idle(10);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
